lap_buffer: RTL and testbench
=============================

# lap_buffer

Lap capture and recall stage between the stopwatch BCD counter and the seven-segment display driver. Snapshots the live tens/ones/tenths digits into a small ring buffer on a lap press and freezes the display on that lap for a fixed hold time. On recall presses it steps through stored laps oldest-first. Its outputs drive the display's three digit inputs in place of the raw counter digits.

## Interface
- DEPTH, 8, number of lap entries; power of two, 2..16
- HOLD_CYCLES, 200000000, cycles the display freezes after a lap (2 s at 100 MHz); ≥2, fits 28 bits

- clk  in  1  100 MHz system clock
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- lap_btn  in  1  debounced lap button level
- recall_btn  in  1  debounced recall button level
- clear  in  1  debounced clear level; empties buffer while high
- live_tens, live_ones, live_tenths  in  4 each  BCD digits from stopwatch counter
- disp_tens, disp_ones, disp_tenths  out  4 each  registered BCD digits to display
- mode  out  2  00 LIVE, 01 HOLD, 10 RECALL
- lap_count  out  5  entries stored, 0..DEPTH
- recall_idx  out  4  index of entry shown in RECALL, 0 = oldest
- full  out  1  lap_count == DEPTH

## Operation
- Rising-edge detect on lap_btn and recall_btn: previous-level registers, reset to 0; an event is level 1 now, 0 on the previous edge.
- Ring buffer: DEPTH×12-bit memory, write pointer, oldest pointer (rd_base), lap_count. Memory contents are not reset.
- Capture: write {live_tens, live_ones, live_tenths} at the write pointer, advance the pointer mod DEPTH, increment lap_count, load the hold register with the same value, load the timer with HOLD_CYCLES-1, and go to HOLD.
- LIVE: disp = live digits. A lap event captures. A recall event with lap_count>0 goes to RECALL with recall_idx=0. A recall event with lap_count=0 is ignored.
- HOLD: disp = hold register. The timer decrements each cycle; at 0 the next state is LIVE. A lap event captures again and restarts the timer. A recall event with lap_count>0 goes to RECALL with idx 0.
- RECALL: disp = mem[(rd_base+recall_idx) mod DEPTH]. On a recall event, idx increments if idx<lap_count-1; otherwise the state goes to LIVE and idx goes to 0. A lap event captures and goes to HOLD.
- Lap event while full: behaviour per Configuration.
- Lap and recall events on the same edge: lap wins, recall is dropped.
- clear high: pointers and lap_count go to 0, mode goes to LIVE, idx goes to 0, and the timer goes to 0. Clear overrides any same-cycle lap or recall event. Edge-detect registers keep tracking the inputs.
- Reset: same as clear. Additionally, edge registers go to 0 and disp_* go to 0. mode=00, lap_count=0, recall_idx=0, full=0.

## Timing
- All state updates on the rising edge of clk; no combinational path from inputs to outputs.
- Lap event sampled at edge E: memory write, lap_count, full and mode=HOLD are visible after E. disp_* show the captured value after E+1.
- LIVE display latency: disp_* equal the live digits sampled one edge earlier.
- HOLD lasts exactly HOLD_CYCLES cycles: entry at edge E, mode=LIVE after edge E+HOLD_CYCLES.
- RECALL step: recall_idx updates after the event edge; disp_* update one edge later.
- Reset or clear mid-HOLD or mid-RECALL: mode=LIVE after that edge; disp_* track live digits from the following edge.

## Configuration
- LAP_OVERWRITE_EN undefined: a lap event while full is fully ignored. No write, no state change, no timer reload.
- LAP_OVERWRITE_EN defined: a lap event while full overwrites the oldest entry, advances rd_base with the write pointer, keeps lap_count=DEPTH, and enters HOLD as a normal capture. Recall order stays oldest-first.

## Test plan
- Reset, live=1,2,3 steady: disp=0/0/0 after reset, then 1/2/3 one edge after reset deasserts; mode=00, lap_count=0.
- Live=0,4,7, lap pulse at edge E (HOLD_CYCLES=10 for sim): mode=01 after E, disp=0/4/7 after E+1 while live changes, mode=00 after E+10, lap_count=1.
- Three laps at 0.5, 1.2, 3.9, then four recall presses: disp=0/0/5, 0/1/2, 0/3/9, recall_idx 0,1,2; fourth press gives mode=00 and idx=0.
- DEPTH=4, six laps of values 1..6 tenths:
  - Without the macro: lap_count=4, full=1, and recall shows 1,2,3,4.
  - With LAP_OVERWRITE_EN: recall shows 3,4,5,6.
- Lap and recall events on the same edge in LIVE with lap_count=2: capture occurs, mode=01, lap_count=3.
- clear asserted in RECALL together with a lap event: lap_count=0, mode=00, full=0, no write; a later recall press is ignored.

Source files
------------

// File: rtl/lap_if.sv
// Button, live-digit and display bundle between the stopwatch counter, lap_buffer and display driver.
interface lap_if;
  logic       lap_btn;
  logic       recall_btn;
  logic       clear;
  logic [3:0] live_tens;
  logic [3:0] live_ones;
  logic [3:0] live_tenths;
  logic [3:0] disp_tens;
  logic [3:0] disp_ones;
  logic [3:0] disp_tenths;
  logic [1:0] mode;
  logic [4:0] lap_count;
  logic [3:0] recall_idx;
  logic       full;

  modport master (
    output lap_btn, recall_btn, clear, live_tens, live_ones, live_tenths,
    input  disp_tens, disp_ones, disp_tenths, mode, lap_count, recall_idx, full
  );

  modport slave (
    input  lap_btn, recall_btn, clear, live_tens, live_ones, live_tenths,
    output disp_tens, disp_ones, disp_tenths, mode, lap_count, recall_idx, full
  );
endinterface

// File: rtl/lap_buffer.sv
// Lap capture ring buffer with timed HOLD and oldest-first RECALL of stored laps.
// Optional macro LAP_OVERWRITE_EN: a lap while full overwrites the oldest entry instead of being ignored.
module lap_buffer #(
  parameter int DEPTH       = 8,
  parameter int HOLD_CYCLES = 200000000
) (
  input  logic clk,
  input  logic reset,
  lap_if.slave bus
);
  localparam int          AW        = $clog2(DEPTH);
  localparam logic [27:0] HOLD_INIT = 28'(HOLD_CYCLES - 1);
  localparam logic [4:0]  DEPTH_CNT = 5'(DEPTH);

  typedef enum logic [1:0] {
    LIVE   = 2'b00,
    HOLD   = 2'b01,
    RECALL = 2'b10
  } state_t;

  state_t        state;
  logic [11:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_base;
  logic [AW-1:0] rd_addr;
  logic [4:0]    count;
  logic [3:0]    idx;
  logic [27:0]   timer;
  logic [11:0]   hold_word;
  logic [11:0]   disp_word;
  logic [11:0]   live_word;
  logic [11:0]   recall_word;
  logic          lap_btn_p1;
  logic          recall_btn_p1;
  logic          lap_ev;
  logic          recall_ev;
  logic          is_full;
  logic          capture;

  assign live_word = {bus.live_tens, bus.live_ones, bus.live_tenths};
  assign lap_ev    = bus.lap_btn & ~lap_btn_p1;
  assign recall_ev = bus.recall_btn & ~recall_btn_p1;
  assign is_full   = (count == DEPTH_CNT);

`ifdef LAP_OVERWRITE_EN
  assign capture = lap_ev;
`else
  // A lap while full is treated as if it never happened.
  assign capture = lap_ev & ~is_full;
`endif

  // Pointer width is log2(DEPTH), so the sum wraps mod DEPTH on its own.
  assign rd_addr     = rd_base + idx[AW-1:0];
  assign recall_word = mem[rd_addr];

  always_ff @(posedge clk) begin
    if (!reset && !bus.clear && capture) begin
      mem[wr_ptr] <= live_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lap_btn_p1    <= 1'b0;
      recall_btn_p1 <= 1'b0;
      state         <= LIVE;
      wr_ptr        <= '0;
      rd_base       <= '0;
      count         <= '0;
      idx           <= '0;
      timer         <= '0;
      disp_word     <= '0;
    end else begin
      lap_btn_p1    <= bus.lap_btn;
      recall_btn_p1 <= bus.recall_btn;

      // Display source follows the state held before this edge.
      case (state)
        HOLD:    disp_word <= hold_word;
        RECALL:  disp_word <= recall_word;
        default: disp_word <= live_word;
      endcase

      if (bus.clear) begin
        state   <= LIVE;
        wr_ptr  <= '0;
        rd_base <= '0;
        count   <= '0;
        idx     <= '0;
        timer   <= '0;
      end else if (capture) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (is_full) begin
          rd_base <= rd_base + AW'(1);
        end else begin
          count <= count + 5'd1;
        end
        hold_word <= live_word;
        timer     <= HOLD_INIT;
        state     <= HOLD;
        idx       <= '0;
      end else if (recall_ev) begin
        if (state == RECALL) begin
          if (({1'b0, idx} + 5'd1) < count) begin
            idx <= idx + 4'd1;
          end else begin
            state <= LIVE;
            idx   <= '0;
          end
        end else if (count != 5'd0) begin
          state <= RECALL;
          idx   <= '0;
        end
      end else if (state == HOLD) begin
        if (timer == 28'd0) begin
          state <= LIVE;
        end else begin
          timer <= timer - 28'd1;
        end
      end
    end
  end

  assign bus.disp_tens   = disp_word[11:8];
  assign bus.disp_ones   = disp_word[7:4];
  assign bus.disp_tenths = disp_word[3:0];
  assign bus.mode        = state;
  assign bus.lap_count   = count;
  assign bus.recall_idx  = idx;
  assign bus.full        = is_full;
endmodule

// File: tb/tb_lap_buffer.sv
// Directed and randomized bench for lap_buffer against a queue-based lap model (DEPTH=4, HOLD_CYCLES=10).
module tb_lap_buffer;
  localparam int DEPTH = 4;
  localparam int HOLD  = 10;
`ifdef LAP_OVERWRITE_EN
  localparam bit OVW = 1'b1;
`else
  localparam bit OVW = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  lap_if bus ();

  lap_buffer #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: laps kept oldest-first in a queue.
  logic [11:0] q [$];
  int          m_mode;
  int          m_idx;
  int          m_timer;
  logic [11:0] m_hold;
  logic [11:0] m_disp;
  bit          m_lp;
  bit          m_rp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] disp_now();
    return {bus.disp_tens, bus.disp_ones, bus.disp_tenths};
  endfunction

  task automatic tick();
    logic [11:0] live;
    logic [11:0] nd;
    bit le, re;
    @(posedge clk);
    live = {bus.live_tens, bus.live_ones, bus.live_tenths};
    le   = bus.lap_btn && !m_lp;
    re   = bus.recall_btn && !m_rp;
    case (m_mode)
      0:       nd = live;
      1:       nd = m_hold;
      default: nd = q[m_idx];
    endcase
    if (reset) begin
      q.delete();
      m_mode = 0; m_idx = 0; m_timer = 0; m_disp = '0; m_lp = 0; m_rp = 0;
    end else begin
      m_disp = nd;
      m_lp   = bus.lap_btn;
      m_rp   = bus.recall_btn;
      if (bus.clear) begin
        q.delete();
        m_mode = 0; m_idx = 0; m_timer = 0;
      end else if (le && (q.size() < DEPTH || OVW)) begin
        if (q.size() == DEPTH) void'(q.pop_front());
        q.push_back(live);
        m_hold = live; m_timer = HOLD - 1; m_mode = 1; m_idx = 0;
      end else if (re) begin
        if (m_mode == 2) begin
          if (m_idx < q.size() - 1) m_idx++;
          else begin m_mode = 0; m_idx = 0; end
        end else if (q.size() > 0) begin
          m_mode = 2; m_idx = 0;
        end
      end else if (m_mode == 1) begin
        if (m_timer == 0) m_mode = 0;
        else m_timer--;
      end
    end
    #1;
    check("disp", disp_now(), m_disp);
    check("mode", bus.mode, m_mode);
    check("lap_count", bus.lap_count, q.size());
    check("full", bus.full, q.size() == DEPTH);
    if (m_mode == 2) check("recall_idx", bus.recall_idx, m_idx);
  endtask

  task automatic set_live(input logic [3:0] t, input logic [3:0] o, input logic [3:0] te);
    bus.live_tens = t; bus.live_ones = o; bus.live_tenths = te;
  endtask

  task automatic press_lap();
    bus.lap_btn = 1'b1; tick();
    bus.lap_btn = 1'b0; tick();
  endtask

  task automatic do_clear();
    bus.clear = 1'b1; tick();
    bus.clear = 1'b0; tick();
  endtask

  logic [11:0] e3 [3];

  initial begin
    e3 = '{12'h005, 12'h012, 12'h039};
    reset = 1'b1;
    bus.lap_btn = 1'b0; bus.recall_btn = 1'b0; bus.clear = 1'b0;
    set_live(1, 2, 3);

    // Reset and live tracking
    tick(); tick();
    check("rst_disp", disp_now(), 12'h000);
    check("rst_mode", bus.mode, 2'b00);
    reset = 1'b0;
    tick();
    check("live_disp", disp_now(), 12'h123);

    // Single lap and hold duration
    set_live(0, 4, 7);
    bus.lap_btn = 1'b1; tick();
    check("hold_entry_mode", bus.mode, 2'b01);
    bus.lap_btn = 1'b0; set_live(5, 5, 5); tick();
    check("hold_disp", disp_now(), 12'h047);
    for (int i = 0; i < 8; i++) tick();
    check("hold_still", bus.mode, 2'b01);
    tick();
    check("hold_done", bus.mode, 2'b00);
    check("hold_count", bus.lap_count, 5'd1);

    // Three laps then recall stepping
    do_clear();
    set_live(0, 0, 5); press_lap();
    set_live(0, 1, 2); press_lap();
    set_live(0, 3, 9); press_lap();
    for (int k = 0; k < 3; k++) begin
      bus.recall_btn = 1'b1; tick();
      check("recall_step_idx", bus.recall_idx, k);
      bus.recall_btn = 1'b0; tick();
      check("recall_step_disp", disp_now(), e3[k]);
    end
    bus.recall_btn = 1'b1; tick();
    check("recall_exit_mode", bus.mode, 2'b00);
    check("recall_exit_idx", bus.recall_idx, 4'd0);
    bus.recall_btn = 1'b0; tick();

    // Six laps into a four-entry buffer
    do_clear();
    for (int k = 1; k <= 6; k++) begin
      set_live(0, 0, 4'(k)); press_lap();
    end
    check("wrap_count", bus.lap_count, 5'd4);
    check("wrap_full", bus.full, 1'b1);
    for (int k = 0; k < 4; k++) begin
      bus.recall_btn = 1'b1; tick();
      bus.recall_btn = 1'b0; tick();
      check("wrap_recall", disp_now(), OVW ? 12'(3 + k) : 12'(1 + k));
    end
    bus.recall_btn = 1'b1; tick();
    bus.recall_btn = 1'b0; tick();

    // Lap and recall on the same edge
    do_clear();
    set_live(1, 1, 1); press_lap();
    set_live(2, 2, 2); press_lap();
    set_live(3, 3, 3);
    bus.lap_btn = 1'b1; bus.recall_btn = 1'b1; tick();
    check("both_mode", bus.mode, 2'b01);
    check("both_count", bus.lap_count, 5'd3);
    bus.lap_btn = 1'b0; bus.recall_btn = 1'b0; tick();

    // Clear in RECALL beats a simultaneous lap
    bus.recall_btn = 1'b1; tick();
    bus.recall_btn = 1'b0; tick();
    check("pre_clear_mode", bus.mode, 2'b10);
    bus.clear = 1'b1; bus.lap_btn = 1'b1; tick();
    check("clear_count", bus.lap_count, 5'd0);
    check("clear_mode", bus.mode, 2'b00);
    check("clear_full", bus.full, 1'b0);
    bus.clear = 1'b0; bus.lap_btn = 1'b0; tick();
    bus.recall_btn = 1'b1; tick();
    check("empty_recall_mode", bus.mode, 2'b00);
    bus.recall_btn = 1'b0; tick();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset          = ($urandom_range(0, 499) == 0);
      bus.clear      = ($urandom_range(0, 99) == 0);
      bus.lap_btn    = ($urandom_range(0, 5) == 0);
      bus.recall_btn = ($urandom_range(0, 3) == 0);
      set_live(4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
